// File: rtl/song_reader.sv
// Song ROM sequencer: walks the 32 entries of the selected song, dispatches note
// entries to the note players round-robin and holds on wait entries for N beats.
module song_reader #(
   parameter int NUM_PLAYERS = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        play,
   input  logic [1:0]  song,
   input  logic        beat,
   output logic [6:0]  rom_addr,
   input  logic [15:0] rom_dout,
   output logic [5:0]  note_out,
   output logic [5:0]  duration_out,
   output logic [2:0]  meta_out,
   output logic [2:0]  load_note,
   output logic        song_done
);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ROM_WAIT,
      DECODE,
      WAIT_BEATS,
      DONE
   } state_t;

   state_t      state, state_n;
   logic [1:0]  song_r;
   logic [4:0]  note_index;
   logic [1:0]  slot;
   logic [5:0]  beat_cnt;
   logic [2:0]  load_q;
   logic        done_q;

   logic        song_chg;
   logic        last_entry;
   logic        entry_is_wait;
   logic [5:0]  entry_count;
   logic        dispatch;
   logic        wait_load;
   logic        beat_dec;
   logic        advance;

   assign song_chg      = (song != song_r);
   assign last_entry    = (note_index == 5'd31);
   assign entry_is_wait = rom_dout[15];
   assign entry_count   = rom_dout[14:9];

   // Pulses are masked the moment play drops so nothing reaches a player while paused.
   assign load_note = load_q & {3{play}};
   assign song_done = done_q & play;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      dispatch  = 1'b0;
      wait_load = 1'b0;
      beat_dec  = 1'b0;
      advance   = 1'b0;
      if (song_chg) begin
         state_n = IDLE;
      end else if (play) begin
         case (state)
            IDLE:     state_n = FETCH;
            FETCH:    state_n = ROM_WAIT;
            ROM_WAIT: state_n = DECODE;
            DECODE: begin
               if (!entry_is_wait) begin
                  dispatch = 1'b1;
                  advance  = 1'b1;
               end else if (entry_count == 6'd0) begin
                  advance = 1'b1;
               end else begin
                  wait_load = 1'b1;
                  state_n   = WAIT_BEATS;
               end
            end
            WAIT_BEATS: begin
               if (beat) begin
                  beat_dec = 1'b1;
                  advance  = (beat_cnt == 6'd1);
               end
            end
            DONE:    state_n = DONE;
            default: state_n = IDLE;
         endcase
         if (advance) state_n = last_entry ? DONE : FETCH;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         song_r       <= 2'd0;
         rom_addr     <= 7'd0;
         note_index   <= 5'd0;
         slot         <= 2'd0;
         beat_cnt     <= 6'd0;
         note_out     <= 6'd0;
         duration_out <= 6'd0;
         meta_out     <= 3'd0;
         load_q       <= 3'd0;
         done_q       <= 1'b0;
      end else begin
         song_r <= song;
         load_q <= 3'd0;
         done_q <= 1'b0;
         if (song_chg) begin
            note_index <= 5'd0;
            beat_cnt   <= 6'd0;
            slot       <= 2'd0;
         end else if (play) begin
            if (state == IDLE) begin
               note_index <= 5'd0;
               slot       <= 2'd0;
               rom_addr   <= {song, 5'd0};
            end
            if (dispatch) begin
               note_out     <= rom_dout[14:9];
               duration_out <= rom_dout[8:3];
               meta_out     <= rom_dout[2:0];
               load_q       <= 3'b001 << slot;
               slot         <= (slot == 2'(NUM_PLAYERS - 1)) ? 2'd0 : slot + 2'd1;
            end
            if (wait_load) beat_cnt <= entry_count;
            if (beat_dec)  beat_cnt <= beat_cnt - 6'd1;
            // The address for the next entry is presented on the same edge that enters FETCH.
            if (advance) begin
               if (last_entry) begin
                  note_index <= 5'd0;
                  done_q     <= 1'b1;
               end else begin
                  note_index <= note_index + 5'd1;
                  rom_addr   <= {song, note_index + 5'd1};
               end
            end
         end
      end
   end

endmodule
